hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined CPU. It generalises the fixed E/M/W hazard unit to a configurable number of post-decode stages and a configurable load latency.
- Keeps an internal shift-register scoreboard of in-flight instructions (destination, write-enable, load flag, PC-write flag). From it, it generates stall, flush and forwarding-select signals.
- Adds a multi-cycle execute hold (ExBusyE), which the current hazard unit does not support.

Parameters:
- REG_W, 4, register-address width (2**REG_W architectural registers).
- STAGES, 3, tracked stages after decode; index 0 = E, STAGES-1 = W; legal range 3..8.
- LOAD_LAT, 2, stage index at which load data first becomes forwardable; legal range 1..STAGES-1.
- PC_REG, 15, register index that aliases the PC; never forwarded or stalled on.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ValidD  in  1  decode stage holds a real instruction.
- RA1D, RA2D  in  REG_W  decode source registers.
- WA3D  in  REG_W  decode destination register.
- RegWriteD  in  1  decode instruction writes WA3D.
- MemToRegD  in  1  decode instruction is a load.
- PCSrcD  in  1  decode instruction writes the PC.
- BranchTakenE  in  1  branch resolved taken in E.
- ExBusyE  in  1  multi-cycle operation occupying E.
- StallF, StallD  out  1  hold PC / F-D register.
- FlushD, FlushE  out  1  clear F-D / D-E register.
- ForwardAE, ForwardBE  out  $clog2(STAGES)  0 = regfile, k = result of scoreboard entry k.
- StallCnt, FlushCnt  out  32  performance counters (see Optional Feature).

Behaviour:
- Scoreboard: STAGES entries {valid, we, dst, ld, pcwr}. Entry 0 also holds the E-stage sources ra1E and ra2E.
- Reset: all entries invalid and fields zero. With all inputs low, every output is 0.
- Normal advance (no stall, no ExBusyE):
  - entry[i] <= entry[i-1] for i = 1..STAGES-1.
  - entry[0] <= {ValidD, RegWriteD, WA3D, MemToRegD, PCSrcD, RA1D, RA2D}, or a bubble when FlushE=1.
  - entry[STAGES-1] retires.
- Match(k, r): entry[k].valid & entry[k].we & entry[k].dst==r & r!=PC_REG.
- Forwarding (combinational from state): ForwardAE = the smallest k in 1..STAGES-1 with Match(k, ra1E) & !(entry[k].ld & k<LOAD_LAT); 0 if there is none. ForwardBE uses ra2E in the same way. The youngest producer wins.
- Load-use stall LdStall: ValidD and there exists j in 0..STAGES-2 with entry[j].ld & Match(j, RA1D or RA2D) & (j+1)<LOAD_LAT.
- PCWrPending: (ValidD & PCSrcD) or any entry[j].pcwr & valid for j in 0..STAGES-2.
- Output equations:
  - StallF = LdStall | PCWrPending | ExBusyE.
  - StallD = LdStall | ExBusyE.
  - FlushD = PCWrPending | (entry[STAGES-1].pcwr & valid) | BrT, where BrT = BranchTakenE & !ExBusyE.
  - FlushE = LdStall | BrT.
- ExBusyE=1:
  - entry[0] holds its value.
  - entry[1] <= bubble; entries 2.. advance.
  - BranchTakenE is ignored.
  - Forwarding continues from the advancing entries.
- Simultaneous BrT and LdStall: the branch wins. StallF=StallD=0, FlushD=FlushE=1, and entry[0] <= bubble.
- Reads of PC_REG never cause a stall or a forward.
- Asynchronous reset asserted mid-operation clears the scoreboard immediately. Outputs drop to their reset values in the same cycle.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined:
  - StallCnt increments on every cycle with StallD=1.
  - FlushCnt increments on every cycle with FlushE=1.
  - Both counters are 32 bits, wrap 0xFFFFFFFF->0, and are cleared by Reset.
- When not defined: the counter flops are not built and StallCnt = FlushCnt = 0 constantly.

Test Plan:
- Reset asserted while the scoreboard holds 3 valid entries -> same cycle: all outputs 0 and scoreboard cleared; after release with ValidD=0 the outputs stay 0.
- Defaults. Issue ADD r1 (we, dst=1), then SUB with RA1D=1 next cycle -> when SUB is in E, ForwardAE=1. One cycle later, an instruction reading r1 gets ForwardAE=2.
- Defaults. LDR r2, then ADD with RA2D=2 immediately -> exactly 1 cycle of StallF=StallD=FlushE=1. Then ForwardBE=2 when the ADD is in E; StallCnt=1 with HAZ_PERF_CNT_EN.
- STAGES=5, LOAD_LAT=3. LDR r4 followed by a consumer of r4 -> 2 stall cycles. A consumer of r4 issued 3 cycles after the LDR sees no stall and ForwardAE=3.
- BranchTakenE=1 in the same cycle as an LdStall condition -> StallD=0, FlushD=FlushE=1, and entry[0] is a bubble on the next cycle.
- ExBusyE=1 for 4 cycles with ADD r3 in E -> StallF=StallD=1 for 4 cycles and BranchTakenE is ignored. ADD r3 then advances, and a dependent instruction gets ForwardAE=1.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bundle: decode/execute status in, pipeline control out.
//   master : pipeline side, drives decode/execute status, receives control.
//   slave  : hazard_scoreboard side.
//   Decode status  : ValidD, RA1D, RA2D, WA3D, RegWriteD, MemToRegD, PCSrcD
//   Execute status : BranchTakenE, ExBusyE
//   Control        : StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
//   Perf counters  : StallCnt, FlushCnt
interface hazard_scoreboard_if #(
    parameter int unsigned REG_W  = 4,
    parameter int unsigned STAGES = 3
);
    localparam int unsigned FWD_W = $clog2(STAGES);

    logic             ValidD;
    logic [REG_W-1:0] RA1D;
    logic [REG_W-1:0] RA2D;
    logic [REG_W-1:0] WA3D;
    logic             RegWriteD;
    logic             MemToRegD;
    logic             PCSrcD;
    logic             BranchTakenE;
    logic             ExBusyE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic [FWD_W-1:0] ForwardAE;
    logic [FWD_W-1:0] ForwardBE;
    logic [31:0]      StallCnt;
    logic [31:0]      FlushCnt;

    modport master (
        output ValidD, RA1D, RA2D, WA3D, RegWriteD, MemToRegD, PCSrcD,
        output BranchTakenE, ExBusyE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
        input  StallCnt, FlushCnt
    );

    modport slave (
        input  ValidD, RA1D, RA2D, WA3D, RegWriteD, MemToRegD, PCSrcD,
        input  BranchTakenE, ExBusyE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
        output StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Parametrised hazard/forwarding controller. A shift-register scoreboard of
// in-flight instructions (entry 0 = E, entry STAGES-1 = W) drives stall,
// flush and forwarding-select outputs; supports a multi-cycle E hold.
// Ports:
//   CLK   : clock, rising edge
//   Reset : asynchronous, active-high
//   hz    : hazard_scoreboard_if.slave (decode/execute status in, control out)
// Optional feature: define HAZ_PERF_CNT_EN to build the StallCnt/FlushCnt
// performance counters; otherwise both outputs are tied to zero.
module hazard_scoreboard #(
    parameter int unsigned REG_W    = 4,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned PC_REG   = 15
) (
    input  logic                CLK,
    input  logic                Reset,
    hazard_scoreboard_if.slave  hz
);
    localparam int unsigned FWD_W   = $clog2(STAGES);
    localparam int          Last    = int'(STAGES) - 1;
    localparam int          LoadLat = int'(LOAD_LAT);

    typedef struct packed {
        logic             valid;
        logic             we;
        logic [REG_W-1:0] dst;
        logic             ld;
        logic             pcwr;
    } sbEntry_t;

    sbEntry_t [STAGES-1:0] entry;
    logic [REG_W-1:0]      ra1E;
    logic [REG_W-1:0]      ra2E;

    sbEntry_t         decodeEntry;
    logic             ldStall;
    logic             ldStallEff;
    logic             pcWrPending;
    logic             brT;
    logic             stallD;
    logic             flushE;
    logic [FWD_W-1:0] forwardA;
    logic [FWD_W-1:0] forwardB;

    // Entry k produces register r (the PC alias is never a producer).
    function automatic logic match(input sbEntry_t e, input logic [REG_W-1:0] r);
        return e.valid & e.we & (e.dst == r) & (r != REG_W'(PC_REG));
    endfunction

    // Decode-stage instruction as it would enter E.
    always_comb begin
        decodeEntry       = '0;
        decodeEntry.valid = hz.ValidD;
        decodeEntry.we    = hz.RegWriteD;
        decodeEntry.dst   = hz.WA3D;
        decodeEntry.ld    = hz.MemToRegD;
        decodeEntry.pcwr  = hz.PCSrcD;
    end

    // Load-use: a load whose data is not yet forwardable when the consumer reaches E.
    always_comb begin
        ldStall = 1'b0;
        for (int j = 0; j < Last; j++) begin
            if (entry[j].ld && ((j + 1) < LoadLat) &&
                (match(entry[j], hz.RA1D) || match(entry[j], hz.RA2D))) begin
                ldStall = 1'b1;
            end
        end
        ldStall = ldStall & hz.ValidD;
    end

    // PC writes in decode or in any stage before W hold fetch.
    always_comb begin
        pcWrPending = hz.ValidD & hz.PCSrcD;
        for (int j = 0; j < Last; j++) begin
            if (entry[j].valid && entry[j].pcwr) begin
                pcWrPending = 1'b1;
            end
        end
    end

    // Youngest forwardable producer wins: scan oldest first, younger overwrite.
    always_comb begin
        forwardA = '0;
        forwardB = '0;
        for (int k = Last; k >= 1; k--) begin
            if (match(entry[k], ra1E) && !(entry[k].ld && (k < LoadLat))) begin
                forwardA = FWD_W'(k);
            end
            if (match(entry[k], ra2E) && !(entry[k].ld && (k < LoadLat))) begin
                forwardB = FWD_W'(k);
            end
        end
    end

    // A taken branch overrides a load-use stall; a busy E masks the branch.
    always_comb begin
        brT        = hz.BranchTakenE & ~hz.ExBusyE;
        ldStallEff = ldStall & ~brT;
        stallD     = ldStallEff | hz.ExBusyE;
        flushE     = ldStall | brT;
    end

    assign hz.StallF    = ldStallEff | pcWrPending | hz.ExBusyE;
    assign hz.StallD    = stallD;
    assign hz.FlushD    = pcWrPending | (entry[Last].valid & entry[Last].pcwr) | brT;
    assign hz.FlushE    = flushE;
    assign hz.ForwardAE = forwardA;
    assign hz.ForwardBE = forwardB;

    // Scoreboard advance; a busy E holds entry 0 and injects a bubble behind it.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            entry <= '0;
            ra1E  <= '0;
            ra2E  <= '0;
        end else begin
            for (int i = 2; i <= Last; i++) begin
                entry[i] <= entry[i-1];
            end
            if (hz.ExBusyE) begin
                entry[1] <= '0;
            end else begin
                entry[1] <= entry[0];
                if (flushE) begin
                    entry[0] <= '0;
                    ra1E     <= '0;
                    ra2E     <= '0;
                end else begin
                    entry[0] <= decodeEntry;
                    ra1E     <= hz.RA1D;
                    ra2E     <= hz.RA2D;
                end
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    // Free-running wrap-around event counters.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallD) stallCnt <= stallCnt + 32'd1;
            if (flushE) flushCnt <= flushCnt + 32'd1;
        end
    end

    assign hz.StallCnt = stallCnt;
    assign hz.FlushCnt = flushCnt;
`else
    assign hz.StallCnt = '0;
    assign hz.FlushCnt = '0;
`endif
endmodule
